// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin share of the single RF write port
// between NUM_REQ requesters, plus the pending-write scoreboard used for RAW stalls.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      claim_valid,
  input  logic [ADDR_W-1:0]         claim_addr,
  input  logic [ADDR_W-1:0]         q_addr1,
  input  logic [ADDR_W-1:0]         q_addr2,
  output logic                      q_busy1,
  output logic                      q_busy2,
  output logic [(1<<ADDR_W)-1:0]    busy_mask
);

  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [PTR_W-1:0]    rrPtr;
  logic [PTR_W-1:0]    grantIdx;
  logic                grantFound;
  logic [ADDR_W-1:0]   grantAddr;
  logic [DATA_W-1:0]   grantData;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busyNext;

  // Rotating priority search starting at rrPtr.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rrPtr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grantFound && req_valid[idx]) begin
        grantFound = 1'b1;
        grantIdx   = idx[PTR_W-1:0];
      end
    end
  end

  assign req_ready = grantFound ? (NUM_REQ'(1) << grantIdx) : '0;
  assign grantAddr = req_addr[grantIdx*ADDR_W +: ADDR_W];
  assign grantData = req_data[grantIdx*DATA_W +: DATA_W];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (grantFound) begin
      rrPtr    <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      rf_we    <= (grantAddr != '0);
      rf_waddr <= grantAddr;
      rf_wdata <= grantData;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // The commit clear is applied first so a same-edge claim of that register wins.
  always_comb begin
    busyNext = busy;
    if (rf_we) busyNext[rf_waddr] = 1'b0;
    if (claim_valid && claim_addr != '0) busyNext[claim_addr] = 1'b1;
    busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busyNext;
  end

  assign busy_mask = busy;
  assign q_busy1   = busy[q_addr1];
  assign q_busy2   = busy[q_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: table-driven arbitration vectors plus
// hand-written scoreboard, collision and mid-write reset sequences.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        claim_valid = 1'b0;
  logic [4:0]  claim_addr = '0;
  logic [4:0]  q_addr1 = '0;
  logic [4:0]  q_addr2 = '0;
  logic        q_busy1, q_busy2;
  logic [31:0] busy_mask;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  addr0;
    logic [31:0] data0;
    logic [2:0]  expReady;
    logic        expWe;
    logic [4:0]  expWaddr;
    logic [31:0] expWdata;
  } vec_t;

  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'h2222_2222;
  localparam logic [31:0] D2 = 32'h3333_3333;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid   = '0;
    claim_valid = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    // Requesters 1/2 write regs 2/3; requester 0 writes reg 1 except the reg-0 row.
    vecs[0]  = '{3'b111, 5'd1, D0, 3'b001, 1'b1, 5'd1, D0};
    vecs[1]  = '{3'b111, 5'd1, D0, 3'b010, 1'b1, 5'd2, D1};
    vecs[2]  = '{3'b111, 5'd1, D0, 3'b100, 1'b1, 5'd3, D2};
    vecs[3]  = '{3'b111, 5'd1, D0, 3'b001, 1'b1, 5'd1, D0};
    vecs[4]  = '{3'b111, 5'd1, D0, 3'b010, 1'b1, 5'd2, D1};
    vecs[5]  = '{3'b111, 5'd1, D0, 3'b100, 1'b1, 5'd3, D2};
    vecs[6]  = '{3'b001, 5'd1, D0, 3'b001, 1'b1, 5'd1, D0};
    vecs[7]  = '{3'b101, 5'd1, D0, 3'b100, 1'b1, 5'd3, D2};
    vecs[8]  = '{3'b101, 5'd1, D0, 3'b001, 1'b1, 5'd1, D0};
    vecs[9]  = '{3'b000, 5'd1, D0, 3'b000, 1'b0, 5'd1, D0};
    vecs[10] = '{3'b001, 5'd0, 32'h1234_5678, 3'b001, 1'b0, 5'd0, 32'h1234_5678};
    vecs[11] = '{3'b110, 5'd1, D0, 3'b010, 1'b1, 5'd2, D1};
    vecs[12] = '{3'b011, 5'd1, D0, 3'b001, 1'b1, 5'd1, D0};

    // Reset with random inputs toggling.
    for (int c = 0; c < 3; c++) begin
      req_valid   = 3'($urandom);
      req_addr    = 15'($urandom);
      req_data    = {$urandom, $urandom, $urandom};
      claim_valid = 1'($urandom);
      claim_addr  = 5'($urandom);
      q_addr1     = 5'($urandom);
      q_addr2     = 5'($urandom);
      step();
      check("rst_we", 32'(rf_we), 32'd0);
      check("rst_waddr", 32'(rf_waddr), 32'd0);
      check("rst_wdata", rf_wdata, 32'd0);
      check("rst_busy", busy_mask, 32'd0);
      check("rst_qbusy", {30'd0, q_busy1, q_busy2}, 32'd0);
    end
    idle();
    req_addr = '0;
    req_data = '0;
    rst = 1'b0;
    #1;
    check("rst_ready_idle", 32'(req_ready), 32'd0);
    step();

    // Arbitration table.
    for (int i = 0; i < 13; i++) begin
      req_valid = vecs[i].valid;
      req_addr  = {5'd3, 5'd2, vecs[i].addr0};
      req_data  = {D2, D1, vecs[i].data0};
      #1;
      check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
      step();
      check($sformatf("v%0d_we", i), 32'(rf_we), 32'(vecs[i].expWe));
      check($sformatf("v%0d_waddr", i), 32'(rf_waddr), 32'(vecs[i].expWaddr));
      check($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].expWdata);
    end
    idle();
    step();
    // rr_ptr now 1.

    // Single write to reg 5 tracked through the scoreboard.
    claim_valid = 1'b1;
    claim_addr  = 5'd5;
    q_addr1     = 5'd5;
    q_addr2     = 5'd0;
    #1;
    check("sw_qbusy_pre", 32'(q_busy1), 32'd0);
    step();
    claim_valid = 1'b0;
    check("sw_busy_set", busy_mask, 32'h0000_0020);
    check("sw_qbusy1", 32'(q_busy1), 32'd1);
    check("sw_qbusy2_r0", 32'(q_busy2), 32'd0);
    step();
    req_valid = 3'b010;
    req_addr  = {5'd0, 5'd5, 5'd0};
    req_data  = {32'd0, 32'hDEAD_BEEF, 32'd0};
    #1;
    check("sw_ready", 32'(req_ready), 32'b010);
    step();
    req_valid = '0;
    check("sw_we", 32'(rf_we), 32'd1);
    check("sw_waddr", 32'(rf_waddr), 32'd5);
    check("sw_wdata", rf_wdata, 32'hDEAD_BEEF);
    check("sw_busy_hold", 32'(q_busy1), 32'd1);
    step();
    check("sw_we_drop", 32'(rf_we), 32'd0);
    check("sw_busy_clr", busy_mask, 32'd0);
    check("sw_qbusy_clr", 32'(q_busy1), 32'd0);

    // Claim of reg 0 is ignored.
    claim_valid = 1'b1;
    claim_addr  = 5'd0;
    step();
    claim_valid = 1'b0;
    check("r0_claim", busy_mask, 32'd0);

    // Set/clear collision on reg 7 (rr_ptr = 2).
    claim_valid = 1'b1;
    claim_addr  = 5'd7;
    step();
    claim_valid = 1'b0;
    req_valid   = 3'b001;
    req_addr    = {5'd0, 5'd0, 5'd7};
    req_data    = {32'hC2, 32'd0, 32'hC0};
    #1;
    check("col_ready0", 32'(req_ready), 32'b001);
    step();
    req_valid   = '0;
    claim_valid = 1'b1;
    claim_addr  = 5'd7;
    check("col_we", 32'(rf_we), 32'd1);
    check("col_waddr", 32'(rf_waddr), 32'd7);
    step();
    claim_valid = 1'b0;
    check("col_set_wins", busy_mask, 32'h0000_0080);
    req_valid = 3'b100;
    req_addr  = {5'd7, 5'd0, 5'd0};
    #1;
    check("col_ready2", 32'(req_ready), 32'b100);
    step();
    req_valid = '0;
    check("col_wdata2", rf_wdata, 32'hC2);
    step();
    check("col_clear", busy_mask, 32'd0);

    // Mid-write reset with reg 9 claimed and in flight.
    claim_valid = 1'b1;
    claim_addr  = 5'd9;
    step();
    claim_valid = 1'b0;
    req_valid   = 3'b001;
    req_addr    = {5'd0, 5'd0, 5'd9};
    req_data    = {32'd0, 32'd0, 32'h0909_0909};
    step();
    req_valid = '0;
    check("mr_we_before", 32'(rf_we), 32'd1);
    check("mr_busy_before", busy_mask, 32'h0000_0200);
    #2;
    rst = 1'b1;
    #1;
    check("mr_we_async", 32'(rf_we), 32'd0);
    check("mr_busy_async", busy_mask, 32'd0);
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("mr_no_write%0d", c), 32'(rf_we), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
